// File: rtl/ldw_mem_bus.sv
// Data-side memory-mapped responder for the CPU MEM stage.
// Serves data RAM, a keyboard scan-code FIFO, the VGA text-buffer write
// port, a free-running cycle timer and an LED register. Reads are
// combinational so the MEM/WB register captures them at the next edge;
// every write and read side effect commits on the rising clock edge.
module ldw_mem_bus #(
    parameter int RAM_AW         = 12,
    parameter int KBD_DEPTH_LOG2 = 4,
    parameter int VGA_AW         = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_we,
    input  logic              mem_rd,
    output logic [31:0]       mem_rdata,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    output logic              vga_we,
    output logic [VGA_AW-1:0] vga_addr,
    output logic [7:0]        vga_data,
    output logic [15:0]       led,
    output logic              bus_err
);

    localparam int KBD_DEPTH = 1 << KBD_DEPTH_LOG2;
    localparam logic [KBD_DEPTH_LOG2:0] KBD_FULL_COUNT = (KBD_DEPTH_LOG2 + 1)'(KBD_DEPTH);

    // Region select lines
    logic [3:0] region;
    logic       sel_ram;
    logic       sel_vga;
    logic       sel_stat;
    logic       sel_data;
    logic       sel_timer;
    logic       sel_led;
    logic       mapped;

    // Data RAM
    logic [31:0]       ram [0:(1<<RAM_AW)-1];
    logic [RAM_AW-1:0] ram_idx;

    // Keyboard FIFO state
    logic [7:0]                fifo_mem [0:KBD_DEPTH-1];
    logic [KBD_DEPTH_LOG2-1:0] rd_ptr;
    logic [KBD_DEPTH_LOG2-1:0] wr_ptr;
    logic [KBD_DEPTH_LOG2:0]   count;
    logic                      ovf;
    logic                      fifo_empty;
    logic                      fifo_full;

    // Per-cycle control strobes
    logic        read_only;
    logic        fifo_pop;
    logic        fifo_push;
    logic        ovf_event;
    logic        stat_clear;
    logic [31:0] stat_word;
    logic [31:0] timer;

    assign region    = mem_addr[31:28];
    assign sel_ram   = (region == 4'h0);
    assign sel_vga   = (region == 4'h2);
    assign sel_stat  = (region == 4'h3) && (mem_addr[27:0] == 28'h0);
    assign sel_data  = (region == 4'h3) && (mem_addr[27:0] == 28'h4);
    assign sel_timer = (region == 4'h4);
    assign sel_led   = (region == 4'h5);
    assign mapped    = sel_ram | sel_vga | sel_stat | sel_data | sel_timer | sel_led;

    assign ram_idx = mem_addr[RAM_AW+1:2];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == KBD_FULL_COUNT);

    // A simultaneous store wins over a load, so side effects need rd without we.
    assign read_only  = mem_rd & ~mem_we;
    assign fifo_pop   = read_only & sel_data & ~fifo_empty;
    assign fifo_push  = kbd_valid & (~fifo_full | fifo_pop);
    assign ovf_event  = kbd_valid & fifo_full & ~fifo_pop;
    assign stat_clear = read_only & sel_stat;

    assign stat_word = {19'b0, 5'(count), 6'b0, ovf, ~fifo_empty};

    // Combinational read mux; VGA and unmapped regions read as zero
    always_comb begin
        mem_rdata = '0;
        if (sel_ram) begin
            mem_rdata = ram[ram_idx];
        end else if (sel_stat) begin
            mem_rdata = stat_word;
        end else if (sel_data) begin
            mem_rdata = fifo_empty ? 32'h0 : {24'b0, fifo_mem[rd_ptr]};
        end else if (sel_timer) begin
            mem_rdata = timer;
        end else if (sel_led) begin
            mem_rdata = {16'b0, led};
        end
    end

    // RAM word write; contents survive reset but a store during reset is dropped
    always_ff @(posedge clock) begin
        if (mem_we && sel_ram && !reset) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    // FIFO storage write; the pointer logic decides whether the entry counts
    always_ff @(posedge clock) begin
        if (fifo_push && !reset) begin
            fifo_mem[wr_ptr] <= kbd_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                count <= count + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                count <= count - 1'b1;
            end
            if (ovf_event) begin
                ovf <= 1'b1;
            end else if (stat_clear) begin
                ovf <= 1'b0;
            end
        end
    end

    // Free-running cycle timer; a store restarts it from zero
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (mem_we && sel_timer) begin
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // LED register
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else if (mem_we && sel_led) begin
            led <= mem_wdata[15:0];
        end
    end

    // One-cycle text-buffer write strobe with its address and character
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_we   <= 1'b0;
            vga_addr <= '0;
            vga_data <= '0;
        end else begin
            vga_we <= mem_we & sel_vga;
            if (mem_we && sel_vga) begin
                vga_addr <= mem_addr[VGA_AW-1:0];
                vga_data <= mem_wdata[7:0];
            end
        end
    end

    // Sticky flag for any access into an unmapped hole
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if ((mem_we || mem_rd) && !mapped) begin
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ldw_mem_bus.sv
// Self-checking bench for ldw_mem_bus: directed scenarios plus a random
// phase, all compared against a queue/array based behavioural model.
module tb_ldw_mem_bus;

    logic        clock;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        vga_we;
    logic [11:0] vga_addr;
    logic [7:0]  vga_data;
    logic [15:0] led;
    logic        bus_err;

    int tests_run;
    int tests_failed;

    // Behavioural model state
    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic [31:0] m_timer;
    logic [15:0] m_led;
    logic        m_bus_err;
    logic        m_vga_we;
    logic [11:0] m_vga_addr;
    logic [7:0]  m_vga_data;
    logic [31:0] m_ram [int];

    ldw_mem_bus #(.RAM_AW(12), .KBD_DEPTH_LOG2(4), .VGA_AW(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .vga_we    (vga_we),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .led       (led),
        .bus_err   (bus_err)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Hard stop in case something stalls
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: run did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic model_mapped(input logic [31:0] addr);
        case (addr[31:28])
            4'h0, 4'h2, 4'h4, 4'h5: return 1'b1;
            4'h3: return (addr[27:0] == 28'h0) || (addr[27:0] == 28'h4);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] r;
        int idx;
        r = 32'h0;
        idx = int'(addr[13:2]);
        case (addr[31:28])
            4'h0: r = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxxxxxx;
            4'h3: begin
                if (addr[27:0] == 28'h0)
                    r = (32'(m_q.size()) * 256) + (m_ovf ? 32'd2 : 32'd0)
                        + ((m_q.size() != 0) ? 32'd1 : 32'd0);
                else if (addr[27:0] == 28'h4)
                    r = (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'h0;
            end
            4'h4: r = m_timer;
            4'h5: r = {16'b0, m_led};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic we, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic kv, input logic [7:0] kd);
        logic [3:0] rg;
        logic is_stat, is_data, rd_only, ovf_event;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_timer = 0; m_led = 0; m_bus_err = 0;
            m_vga_we = 0; m_vga_addr = 0; m_vga_data = 0;
            return;
        end
        rg = addr[31:28];
        is_stat = (rg == 4'h3) && (addr[27:0] == 28'h0);
        is_data = (rg == 4'h3) && (addr[27:0] == 28'h4);
        rd_only = rd && !we;
        if ((we || rd) && !model_mapped(addr)) m_bus_err = 1;
        if (rd_only && is_data && m_q.size() > 0) void'(m_q.pop_front());
        ovf_event = 0;
        if (kv) begin
            if (m_q.size() < 16) m_q.push_back(kd);
            else ovf_event = 1;
        end
        if (rd_only && is_stat) m_ovf = 0;
        if (ovf_event) m_ovf = 1;
        m_timer = (we && rg == 4'h4) ? 32'h0 : m_timer + 32'd1;
        if (we && rg == 4'h5) m_led = wdata[15:0];
        m_vga_we = we && (rg == 4'h2);
        if (m_vga_we) begin
            m_vga_addr = addr[11:0];
            m_vga_data = wdata[7:0];
        end
        if (we && rg == 4'h0) m_ram[int'(addr[13:2])] = wdata;
    endtask

    // Drives one cycle, samples combinational read data, advances the model
    // and returns #1 after the rising edge.
    task automatic applyStimulus(input logic rst, input logic we, input logic rd,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic kv, input logic [7:0] kd,
                                 output logic [31:0] got, output logic [31:0] exp);
        reset = rst; mem_we = we; mem_rd = rd; mem_addr = addr;
        mem_wdata = wdata; kbd_valid = kv; kbd_data = kd;
        #1;
        got = mem_rdata;
        exp = model_read(addr);
        model_step(rst, we, rd, addr, wdata, kv, kd);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic [31:0] g, e;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h5000_0000, 0, 0, 0, g, e);
    endtask

    task automatic push_code(input logic [7:0] code);
        logic [31:0] g, e;
        applyStimulus(0, 0, 0, 32'h5000_0000, 0, 1, code, g, e);
    endtask

    task automatic test_reset();
        logic [31:0] g, e;
        applyStimulus(1, 1, 0, 32'h5000_0000, 32'h0000_FFFF, 0, 0, g, e);
        tests_run++;
        if (led !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_led got %h expected 0000", led); end
        tests_run++;
        if (bus_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_bus_err got %b expected 0", bus_err); end
        tests_run++;
        if (vga_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_vga_we got %b expected 0", vga_we); end
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_stat got %h expected 00000000", g); end
        // Give the low RAM words known contents for later reads
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1, 0, 32'(i * 4), $urandom, 0, 0, g, e);
    endtask

    task automatic test_ram();
        logic [31:0] g, e;
        applyStimulus(0, 1, 0, 32'h0000_0014, 32'h1234_5678, 0, 0, g, e);
        applyStimulus(0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, g, e);
        applyStimulus(0, 0, 1, 32'h0000_0010, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL ram_rd_10 got %h expected deadbeef", g); end
        applyStimulus(0, 0, 1, 32'h0000_0013, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL ram_rd_13 got %h expected deadbeef", g); end
        applyStimulus(0, 0, 1, 32'h0000_0014, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL ram_rd_14 got %h expected 12345678", g); end
    endtask

    task automatic test_kbd_order();
        logic [31:0] g, e;
        logic [7:0] codes [3];
        codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21;
        for (int i = 0; i < 3; i++) push_code(codes[i]);
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0000_0301) begin tests_failed++; $display("[TB] FAIL kbd_stat3 got %h expected 00000301", g); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
            tests_run++;
            if (g !== {24'b0, codes[i]}) begin tests_failed++; $display("[TB] FAIL kbd_order%0d got %h expected %h", i, g, codes[i]); end
        end
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL kbd_empty_data got %h expected 00000000", g); end
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL kbd_empty_stat got %h expected 00000000", g); end
    endtask

    task automatic test_overflow();
        logic [31:0] g, e;
        for (int i = 0; i < 17; i++) push_code(8'(8'h80 + i));
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0000_1003) begin tests_failed++; $display("[TB] FAIL ovf_stat got %h expected 00001003", g); end
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0000_1001) begin tests_failed++; $display("[TB] FAIL ovf_cleared got %h expected 00001001", g); end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
            tests_run++;
            if (g !== 32'(8'h80 + i)) begin tests_failed++; $display("[TB] FAIL ovf_drain%0d got %h expected %h", i, g, 32'(8'h80 + i)); end
        end
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL ovf_dropped got %h expected 00000000", g); end
    endtask

    task automatic test_kbd_boundary();
        logic [31:0] g, e;
        for (int i = 0; i < 16; i++) push_code(8'(8'h60 + i));
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 1, 8'h7E, g, e);
        tests_run++;
        if (g !== 32'h60) begin tests_failed++; $display("[TB] FAIL full_pushpop_data got %h expected 00000060", g); end
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0000_1001) begin tests_failed++; $display("[TB] FAIL full_pushpop_stat got %h expected 00001001", g); end
        for (int i = 1; i < 16; i++) applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h6F) begin tests_failed++; $display("[TB] FAIL full_drain_15 got %h expected 0000006f", g); end
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h7E) begin tests_failed++; $display("[TB] FAIL full_newest_last got %h expected 0000007e", g); end
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 1, 8'h5A, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL empty_pushread got %h expected 00000000", g); end
        applyStimulus(0, 0, 1, 32'h3000_0004, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h5A) begin tests_failed++; $display("[TB] FAIL empty_push_kept got %h expected 0000005a", g); end
    endtask

    task automatic test_vga_led_timer();
        logic [31:0] g, e;
        applyStimulus(0, 1, 0, 32'h2000_0123, 32'h1234_5641, 0, 0, g, e);
        tests_run++;
        if ({vga_we, vga_addr, vga_data} !== {1'b1, 12'h123, 8'h41}) begin
            tests_failed++; $display("[TB] FAIL vga_store got %b/%h/%h expected 1/123/41", vga_we, vga_addr, vga_data); end
        idle(1);
        tests_run++;
        if (vga_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL vga_single got %b expected 0", vga_we); end
        applyStimulus(0, 1, 0, 32'h2000_0005, 32'h0000_0061, 0, 0, g, e);
        tests_run++;
        if ({vga_we, vga_addr, vga_data} !== {1'b1, 12'h005, 8'h61}) begin
            tests_failed++; $display("[TB] FAIL vga_b2b_first got %b/%h/%h expected 1/005/61", vga_we, vga_addr, vga_data); end
        applyStimulus(0, 1, 0, 32'h2000_0006, 32'h0000_0062, 0, 0, g, e);
        tests_run++;
        if ({vga_we, vga_addr, vga_data} !== {1'b1, 12'h006, 8'h62}) begin
            tests_failed++; $display("[TB] FAIL vga_b2b_second got %b/%h/%h expected 1/006/62", vga_we, vga_addr, vga_data); end
        applyStimulus(0, 1, 0, 32'h5000_0000, 32'h1234_ABCD, 0, 0, g, e);
        tests_run++;
        if (led !== 16'hABCD) begin tests_failed++; $display("[TB] FAIL led_store got %h expected abcd", led); end
        applyStimulus(0, 1, 0, 32'h4000_0000, 32'h0, 0, 0, g, e);
        idle(7);
        applyStimulus(0, 0, 1, 32'h4000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'd7) begin tests_failed++; $display("[TB] FAIL timer_count got %0d expected 7", g); end
    endtask

    task automatic test_bus_err();
        logic [31:0] g, e;
        applyStimulus(0, 0, 1, 32'h7000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL unmapped_rd got %h expected 00000000", g); end
        tests_run++;
        if (bus_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bus_err_set got %b expected 1", bus_err); end
        idle(2);
        tests_run++;
        if (bus_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bus_err_sticky got %b expected 1", bus_err); end
    endtask

    task automatic test_reset_midburst();
        logic [31:0] g, e;
        push_code(8'h11);
        push_code(8'h22);
        applyStimulus(0, 1, 0, 32'h5000_0000, 32'h5555, 0, 0, g, e);
        applyStimulus(1, 1, 0, 32'h5000_0000, 32'hFFFF, 1, 8'h33, g, e);
        tests_run++;
        if (led !== 16'h0) begin tests_failed++; $display("[TB] FAIL midreset_led got %h expected 0000", led); end
        tests_run++;
        if (bus_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_bus_err got %b expected 0", bus_err); end
        applyStimulus(0, 0, 1, 32'h3000_0000, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_fifo got %h expected 00000000", g); end
        applyStimulus(0, 0, 1, 32'h0000_0010, 0, 0, 0, g, e);
        tests_run++;
        if (g !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL midreset_ram got %h expected deadbeef", g); end
    endtask

    task automatic test_random();
        logic [31:0] g, e, addr;
        logic rst, we, rd, kv;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 11))
                0, 1, 2: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                3:       addr = 32'h2000_0000 | 32'($urandom_range(0, 4095));
                4, 5:    addr = 32'h3000_0000;
                6, 7, 8: addr = 32'h3000_0004;
                9:       addr = 32'h4000_0000;
                10:      addr = 32'h5000_0000;
                default: addr = ($urandom_range(0, 1) == 0) ? 32'h6000_0000 : 32'h3000_0008;
            endcase
            we = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 1) == 1);
            kv = ($urandom_range(0, 1) == 1);
            applyStimulus(rst, we, rd, addr, $urandom, kv, 8'($urandom), g, e);
            tests_run++;
            if (g !== e) begin tests_failed++; $display("[TB] FAIL rand_rdata n=%0d addr=%h got %h expected %h", n, addr, g, e); end
            tests_run++;
            if (led !== m_led) begin tests_failed++; $display("[TB] FAIL rand_led n=%0d got %h expected %h", n, led, m_led); end
            tests_run++;
            if (bus_err !== m_bus_err) begin tests_failed++; $display("[TB] FAIL rand_bus_err n=%0d got %b expected %b", n, bus_err, m_bus_err); end
            tests_run++;
            if ({vga_we, vga_addr, vga_data} !== {m_vga_we, m_vga_addr, m_vga_data}) begin
                tests_failed++;
                $display("[TB] FAIL rand_vga n=%0d got %b/%h/%h expected %b/%h/%h", n, vga_we, vga_addr, vga_data, m_vga_we, m_vga_addr, m_vga_data);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        clock = 0; reset = 0; mem_addr = 0; mem_wdata = 0;
        mem_we = 0; mem_rd = 0; kbd_valid = 0; kbd_data = 0;
        tests_run = 0; tests_failed = 0;
        m_ovf = 0; m_timer = 0; m_led = 0; m_bus_err = 0;
        m_vga_we = 0; m_vga_addr = 0; m_vga_data = 0;
        #2;
        test_reset();
        test_ram();
        test_kbd_order();
        test_overflow();
        test_kbd_boundary();
        test_vga_led_timer();
        test_bus_err();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ldw_mem_bus.md
Name: ldw_mem_bus

Overview:
- Memory-mapped data-side responder for the pipelined CPU's MEM stage.
- Decodes the CPU data address and serves data RAM, a keyboard scan-code FIFO, the VGA text-buffer write port, a cycle timer and an LED register.
- Read data is returned within the same cycle so the MEM/WB register captures it at the next rising edge.
- All writes and read side effects commit on the rising clock edge.

Parameters:
- RAM_AW, 12, data RAM word-address width (4096 x 32-bit words).
- KBD_DEPTH_LOG2, 4, keyboard FIFO depth = 16 entries of 8 bits.
- VGA_AW, 12, VGA text-buffer byte-address width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  CPU MEM-stage byte address (malu).
- mem_wdata  in  32  CPU store data (mb).
- mem_we  in  1  MEM-stage store enable (mwmem, not clock-qualified).
- mem_rd  in  1  MEM-stage load enable (mm2reg); qualifies read side effects.
- mem_rdata  out  32  read data, combinational from mem_addr and current state.
- kbd_valid  in  1  one-cycle strobe from the PS/2 receiver.
- kbd_data  in  8  scan code, valid when kbd_valid is high.
- vga_we  out  1  registered write strobe to the text buffer.
- vga_addr  out  VGA_AW  registered text-buffer byte address.
- vga_data  out  8  registered character code.
- led  out  16  LED register.
- bus_err  out  1  sticky flag: an access hit an unmapped region.

Behaviour:
- Decode on mem_addr[31:28]:
  - 0x0: RAM. Word index = mem_addr[RAM_AW+1:2]; bits [1:0] are ignored.
  - 0x2: VGA region, write-only.
  - 0x3: keyboard. Offset 0x0 = STAT, offset 0x4 = DATA; other offsets are unmapped.
  - 0x4: TIMER.
  - 0x5: LED.
  - All other values: unmapped.
- Reads:
  - mem_rdata is valid whenever mem_addr is stable, regardless of mem_rd.
  - RAM: stored word, asynchronous read.
  - STAT: {19'b0, count[4:0], 6'b0, ovf, ~empty}.
  - DATA: {24'b0, FIFO head}, or 0 when the FIFO is empty.
  - TIMER: current counter value.
  - LED: {16'b0, led}.
  - VGA and unmapped regions: 0.
- Writes, committed at the rising edge when mem_we=1:
  - RAM: word write.
  - VGA: next cycle vga_we=1, vga_addr=mem_addr[VGA_AW-1:0], vga_data=mem_wdata[7:0]. vga_we is high for exactly one cycle per store; back-to-back stores produce back-to-back strobes.
  - TIMER: counter loads 0, and that write takes priority over the increment that cycle.
  - LED: led <= mem_wdata[15:0].
  - Keyboard region: writes are ignored.
- Read side effects occur only when mem_rd=1 and mem_we=0:
  - DATA read with the FIFO non-empty pops one entry at the edge.
  - STAT read clears ovf at the edge. A same-cycle overflow event wins, so ovf stays 1.
- Keyboard FIFO:
  - Circular buffer, 16 entries. Pointers are KBD_DEPTH_LOG2 bits and wrap modulo 16. count is 0..16.
  - Push when kbd_valid=1 and (not full or pop in the same cycle).
  - Push while full without a pop: data is dropped and ovf is set to 1.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Push while empty with a DATA read in the same cycle: the read returns 0, no pop occurs, the push is accepted and count becomes 1.
- Timer: 32-bit, increments every cycle and wraps from 0xFFFFFFFF to 0.
- bus_err: set to 1 at the edge when (mem_we or mem_rd) targets an unmapped region. It stays set until reset.
- Simultaneous mem_we and mem_rd: treated as a write; no read side effect occurs.
- Reset (synchronous, any cycle, including mid-burst):
  - FIFO pointers, count and ovf go to 0.
  - timer = 0, led = 0, vga_we = 0, vga_addr = 0, vga_data = 0, bus_err = 0.
  - RAM contents are not cleared.
  - A store presented in the same cycle as reset is discarded for every region.

Test Plan:
- RAM store then load: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 -> both return 0xDEADBEEF. Read 0x00000014 -> returns its prior contents unchanged.
- Keyboard FIFO order and empty read: push 0x1C, 0x32, 0x21. STAT reads 0x00000301. DATA reads return 0x1C, 0x32, 0x21 in order. The next DATA read returns 0 and STAT reads 0x00000000.
- Keyboard overflow: push 17 codes with no reads -> STAT = 0x00001003. After that STAT read, the next STAT read = 0x00001001. The 17th code is never returned.
- Keyboard boundary cases: with the FIFO full, push and DATA read in the same cycle -> count stays 16 and the new code is returned last. With the FIFO empty, push 0x5A and DATA read in the same cycle -> read returns 0 and the next DATA read returns 0x5A.
- VGA, LED and timer: store 0x41 to 0x20000123 -> exactly one cycle later vga_we=1, vga_addr=0x123, vga_data=0x41. Store 0xABCD to LED -> led=0xABCD. Store 0 to TIMER, then read it N cycles later -> returns N.
- Error and reset: load from 0x70000000 -> returns 0 and bus_err=1. Assert reset for one cycle while storing to 0x50000000 -> led=0, bus_err=0, FIFO empty, RAM word at 0x10 still 0xDEADBEEF.
